// File: rtl/uart_rx_sampler_if.sv
// Serial receive link: the rxd line into the sampler and the parallel byte/status back out.
interface uart_rx_sampler_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_busy;
  logic       frame_err;

  modport master (output rxd, input rx_data, rx_status, rx_busy, frame_err);
  modport slave  (input rxd, output rx_data, rx_status, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx_sampler.sv
// 16x-oversampled 8N1 UART receiver: majority-of-three sampling at mid-bit,
// one-cycle strobe per good byte, sticky framing error.
module uart_rx_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            uart_clk,
  input  logic            reset,
  uart_rx_sampler_if.slave rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] S0    = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] S1    = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] S2    = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [7:0]             data_q, data_d;
  logic                   stat_q, stat_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q;
  logic                   maj, at_s2, at_last, fall;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign fall    = rxs_d_q & ~rxs;
  assign at_s2   = (tick_q == S2);
  assign at_last = (tick_q == TLAST);
  // Third sample is the live synchronised line in the S2 cycle itself.
  assign maj     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (at_s2 && maj) state_d = IDLE;
             else if (at_last) state_d = DATA;
      DATA:  if (at_last && bit_q == 3'd7) state_d = STOP;
      // Leave half a bit early so a back-to-back start edge is not missed.
      STOP:  if (at_s2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d  = (state_q == IDLE || state_d == IDLE) ? '0 :
              (at_last ? '0 : tick_q + 1'b1);
    s0_d    = (tick_q == S0) ? rxs : s0_q;
    s1_d    = (tick_q == S1) ? rxs : s1_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    stat_d  = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      START: if (at_last) bit_d = 3'd0;
      DATA: begin
        if (at_s2)   shift_d[bit_q] = maj;
        if (at_last) bit_d = bit_q + 3'd1;
      end
      STOP: if (at_s2) begin
        if (maj) begin
          data_d = shift_q;
          stat_d = 1'b1;
          ferr_d = 1'b0;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      rxs_d_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      data_q  <= '0;
      stat_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx.rxd};
      rxs_d_q <= rxs;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      data_q  <= data_d;
      stat_q  <= stat_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_status = stat_q;
  assign rx.rx_busy   = busy_q;
  assign rx.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frames are generated from the line format and
// a queue of expected bytes is checked against every strobe and held value.
module tb_uart_rx_sampler;
  logic uart_clk = 1'b0;
  logic reset    = 1'b0;
  always #5 uart_clk = ~uart_clk;

  uart_rx_sampler_if bus ();
  uart_rx_sampler #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .uart_clk (uart_clk),
    .reset    (reset),
    .rx       (bus)
  );

  typedef struct {
    logic [7:0] d;
    int         t0;
    bit         lat;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  int         vectors = 0, errs = 0, cyc = 0;
  logic [7:0] cur = 8'h00;
  bit         exp_ferr = 1'b0;
  logic       ferr_prev = 1'b0;
  int         ferr_rises = 0;
  int         lat;

  always @(posedge uart_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the byte-level model.
  always @(negedge uart_clk) begin
    if (!reset) begin
      chk("reset_rx_data", bus.rx_data, 32'h0);
      chk("reset_flags", {bus.rx_status, bus.rx_busy, bus.frame_err}, 32'h0);
      cur = 8'h00;
    end else if (bus.rx_status) begin
      if (expq.size() == 0) begin
        vectors++; errs++;
        $display("FAIL unexpected_strobe: got data %0h with no frame pending (cycle %0d)", bus.rx_data, cyc);
      end else begin
        e = expq.pop_front();
        chk("strobe_data", bus.rx_data, e.d);
        chk("strobe_frame_err", bus.frame_err, 32'h0);
        if (e.lat) begin
          lat = cyc - (e.t0 + 1);
          chk("strobe_latency_155_157", (lat >= 155 && lat <= 157), 32'h1);
        end
        cur = e.d;
      end
    end else begin
      chk("rx_data_hold", bus.rx_data, cur);
    end
    if (reset && bus.frame_err && !ferr_prev) ferr_rises++;
    ferr_prev = bus.frame_err;
  end

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) begin @(posedge uart_clk); #1; end
  endtask

  // rate is the bit period in percent of nominal; spike inverts one cycle near
  // the centre of data bit 'spike'; abort_n asserts reset at that cycle.
  task automatic send(input logic [7:0] d, input bit stop, input int rate,
                      input int spike, input int gap, input int abort_n);
    int   nc;
    int   b;
    logic lvl;
    exp_t x;
    nc = (160 * rate + 99) / 100;
    if (stop && abort_n < 0) begin
      x.d = d; x.t0 = cyc; x.lat = (rate == 100);
      expq.push_back(x);
    end
    for (int n = 0; n < nc; n++) begin
      if (n == abort_n) begin
        reset = 1'b0;
        bus.rxd = 1'b1;
        repeat (3) begin @(posedge uart_clk); #1; end
        reset = 1'b1;
        exp_ferr = 1'b0;
        idle(20);
        chk("abort_idle", {bus.rx_busy, bus.frame_err}, 32'h0);
        return;
      end
      b = (n * 100) / (16 * rate);
      lvl = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : stop;
      if (spike >= 0 && n == 16 * (spike + 1) + 9) lvl = ~lvl;
      bus.rxd = lvl;
      @(posedge uart_clk); #1;
    end
    idle(gap);
    exp_ferr = !stop;
    chk("frame_err_after_frame", bus.frame_err, exp_ferr);
  endtask

  initial begin
    int busy_cnt;
    int rises0;
    int rate, gap, spike;
    bit stop;
    logic [7:0] d;

    // Reset held with the line toggling.
    bus.rxd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.rxd = i[0];
      @(posedge uart_clk); #1;
    end
    bus.rxd = 1'b1;
    reset = 1'b1;
    idle(10);
    chk("post_reset_data", bus.rx_data, 32'h00);
    chk("post_reset_flags", {bus.rx_busy, bus.frame_err}, 32'h0);

    // Back-to-back pair, zero idle between.
    send(8'hA5, 1'b1, 100, -1, 0, -1);
    chk("pin_after_a5", bus.rx_data, 32'hA5);
    send(8'h3C, 1'b1, 100, -1, 8, -1);
    chk("pin_after_3c", bus.rx_data, 32'h3C);

    // Short low glitch must not start a frame.
    bus.rxd = 1'b0;
    repeat (4) begin @(posedge uart_clk); #1; end
    bus.rxd = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rx_busy) busy_cnt++;
      @(posedge uart_clk); #1;
    end
    chk("glitch_busy_1_to_10", (busy_cnt >= 1 && busy_cnt <= 10), 32'h1);
    chk("glitch_data_kept", bus.rx_data, 32'h3C);

    // Bad stop bit, then recovery.
    send(8'h55, 1'b0, 100, -1, 20, -1);
    chk("pin_ferr_set", bus.frame_err, 32'h1);
    chk("pin_data_after_bad", bus.rx_data, 32'h3C);
    send(8'h0F, 1'b1, 100, -1, 10, -1);
    chk("pin_after_0f", bus.rx_data, 32'h0F);
    chk("pin_ferr_cleared", bus.frame_err, 32'h0);

    // Break: 40 bit times low.
    rises0 = ferr_rises;
    bus.rxd = 1'b0;
    repeat (640) begin @(posedge uart_clk); #1; end
    chk("break_one_ferr", ferr_rises - rises0, 32'h1);
    chk("break_idle", bus.rx_busy, 32'h0);
    idle(32);
    send(8'hFF, 1'b1, 100, -1, 10, -1);
    chk("pin_after_break", bus.rx_data, 32'hFF);

    // Spike at mid of data bit 3, then +/-3 % bit periods.
    send(8'h96, 1'b1, 100, 3, 10, -1);
    chk("pin_spike", bus.rx_data, 32'h96);
    send(8'h6B, 1'b1, 103, -1, 10, -1);
    chk("pin_slow", bus.rx_data, 32'h6B);
    send(8'hC3, 1'b1, 97, -1, 10, -1);
    chk("pin_fast", bus.rx_data, 32'hC3);

    // Reset mid-byte, then a clean frame.
    send(8'h81, 1'b1, 100, -1, 0, 70);
    send(8'h7E, 1'b1, 100, -1, 10, -1);
    chk("pin_after_abort", bus.rx_data, 32'h7E);

    // Randomised traffic.
    for (int k = 0; k < 30; k++) begin
      d     = 8'($urandom);
      rate  = ($urandom_range(0, 2) == 0) ? 97 : ($urandom_range(0, 1) == 0 ? 103 : 100);
      if ($urandom_range(0, 2) != 0) rate = 100;
      stop  = ($urandom_range(0, 5) != 0);
      spike = (rate == 100 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      gap   = !stop ? 20 : (rate == 100 ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20)));
      send(d, stop, rate, spike, gap, -1);
    end
    idle(20);
    chk("all_frames_strobed", expq.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
